// File: rtl/uart_rx_if.sv
// uart_rx result bus: received word, done strobe and per-frame status.
// o_parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_if #(
  parameter int DBIT = 8
);
  logic [DBIT-1:0] o_data;
  logic            o_rx_done_tick;
  logic            o_frame_err;
`ifdef UART_RX_PARITY_EN
  logic            o_parity_err;

  modport master (
    output o_data,
    output o_rx_done_tick,
    output o_frame_err,
    output o_parity_err
  );

  modport slave (
    input o_data,
    input o_rx_done_tick,
    input o_frame_err,
    input o_parity_err
  );
`else
  modport master (
    output o_data,
    output o_rx_done_tick,
    output o_frame_err
  );

  modport slave (
    input o_data,
    input o_rx_done_tick,
    input o_frame_err
  );
`endif
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver, LSB first, mid-bit sampling.
// Define UART_RX_PARITY_EN to add an even-parity bit and o_parity_err.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic      i_clk,
  input  logic      i_reset,
  input  logic      i_tick,
  input  logic      i_rx,
  uart_rx_if.master bus
);

  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_MID  = SW'(7);
  localparam logic [SW-1:0] S_BIT  = SW'(15);
  localparam logic [SW-1:0] S_STP  = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t state_q, state_d;

  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] data_q, data_d;
  logic            ferr_q, ferr_d;
  logic            done_q, done_d;
  logic            rx_m, rx_s, rx_d;
  logic            fall;
`ifdef UART_RX_PARITY_EN
  logic            par_q, par_d;
  logic            perr_q, perr_d;
`endif

  assign fall = rx_d & ~rx_s;

  // Two-flop synchronizer plus delayed copy for edge detection
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= i_rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  // State and datapath registers
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      ferr_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      data_q  <= data_d;
      ferr_q  <= ferr_d;
      done_q  <= done_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (fall) state_d = S_START;
      S_START:
        if (i_tick && s_q == S_MID)
          state_d = rx_s ? S_IDLE : S_DATA;
      S_DATA:
        if (i_tick && s_q == S_BIT && n_q == N_LAST)
`ifdef UART_RX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
      S_PARITY:
        if (i_tick && s_q == S_BIT) state_d = S_STOP;
      S_STOP:
        if (i_tick && s_q == S_STP) state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  // Counter, shift register and result updates
  always_comb begin
    s_d    = s_q;
    n_d    = n_q;
    b_d    = b_q;
    data_d = data_q;
    ferr_d = ferr_q;
    done_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d  = par_q;
    perr_d = perr_q;
`endif
    unique case (state_q)
      S_IDLE:
        if (fall) s_d = '0;
      S_START:
        if (i_tick) begin
          if (s_q == S_MID) begin
            if (!rx_s) begin
              s_d = '0;
              n_d = '0;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      S_DATA:
        if (i_tick) begin
          if (s_q == S_BIT) begin
            b_d = {rx_s, b_q[DBIT-1:1]};
            s_d = '0;
            if (n_q != N_LAST) n_d = n_q + NW'(1);
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      S_PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (i_tick) begin
          if (s_q == S_BIT) begin
            par_d = rx_s;
            s_d   = '0;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
`endif
      end
      S_STOP:
        if (i_tick) begin
          if (s_q == S_STP) begin
            data_d = b_q;
            ferr_d = ~rx_s;
            done_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_d = (^b_q) ^ par_q;
`endif
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      default: ;
    endcase
  end

  assign bus.o_data         = data_q;
  assign bus.o_rx_done_tick = done_q;
  assign bus.o_frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign bus.o_parity_err   = perr_q;
`endif

endmodule
